ctrl_unit: RTL and testbench

Main decoder and sequencer of the single-issue RV32I core. It decodes the 5-bit major opcode (instruction bits [6:2]), func3, func7 and the branch-condition flag into datapath select, write-enable and ALU-operation controls. It also owns the one-bit `load_phase` register that stretches LOAD instructions to two cycles. It sits between the instruction register and the datapath muxes (immediate, ALU operands, rd write-back, PC, memory address).

---
 rtl/ctrl_unit.sv | 130 +++++++++++++
 tb/tb_ctrl_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ctrl_unit.sv
// Main decoder and LOAD sequencer for the single-issue RV32I core.
// Decode is purely combinational; only the LOAD phase bit is registered.
module ctrl_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       b,
    output logic [2:0] imm_type,
    output logic       alu1_sel,
    output logic       alu2_sel,
    output logic [3:0] alu_op,
    output logic [1:0] rd_sel,
    output logic       reg_wr,
    output logic       mem_wr,
    output logic [1:0] mem_size,
    output logic       mem_unsigned,
    output logic       mem_addr_sel,
    output logic [1:0] pc_sel,
    output logic       load_phase
);

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_U    = 3'b001;
    localparam logic [2:0] IMM_J    = 3'b010;
    localparam logic [2:0] IMM_S    = 3'b011;
    localparam logic [2:0] IMM_I    = 3'b100;
    localparam logic [2:0] IMM_B    = 3'b101;

    // PH_ADDR: address/fetch-hold cycle of a LOAD, PH_WB: write-back cycle.
    typedef enum logic {PH_ADDR = 1'b0, PH_WB = 1'b1} phase_t;
    phase_t state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= PH_ADDR;
        end else if (opcode == OPC_LOAD) begin
            state <= (state == PH_ADDR) ? PH_WB : PH_ADDR;
        end else begin
            state <= PH_ADDR;
        end
    end

    assign load_phase = (state == PH_WB);

    always_comb begin
        imm_type     = IMM_NONE;
        alu1_sel     = 1'b0;
        alu2_sel     = 1'b1;
        alu_op       = 4'b0000;
        rd_sel       = 2'b10;
        reg_wr       = 1'b0;
        mem_wr       = 1'b0;
        mem_size     = 2'b00;
        mem_unsigned = 1'b0;
        mem_addr_sel = 1'b0;
        pc_sel       = 2'b01;
        case (opcode)
            OPC_OP: begin
                alu2_sel = 1'b0;
                reg_wr   = 1'b1;
                // func7[5] selects SUB/SRA only; other func3 ignore it.
                alu_op   = {func7[5] & ((func3 == 3'b000) || (func3 == 3'b101)), func3};
            end
            OPC_OP_IMM: begin
                imm_type = IMM_I;
                reg_wr   = 1'b1;
                alu_op   = {func7[5] & (func3 == 3'b101), func3};
            end
            OPC_LUI: begin
                imm_type = IMM_U;
                rd_sel   = 2'b00;
                reg_wr   = 1'b1;
            end
            OPC_AUIPC: begin
                imm_type = IMM_U;
                alu1_sel = 1'b1;
                reg_wr   = 1'b1;
            end
            OPC_JAL: begin
                imm_type = IMM_J;
                alu1_sel = 1'b1;
                rd_sel   = 2'b01;
                reg_wr   = 1'b1;
                pc_sel   = 2'b00;
            end
            OPC_JALR: begin
                imm_type = IMM_I;
                rd_sel   = 2'b01;
                reg_wr   = 1'b1;
                pc_sel   = 2'b00;
            end
            OPC_BRANCH: begin
                imm_type = IMM_B;
                alu1_sel = 1'b1;
                pc_sel   = b ? 2'b00 : 2'b01;
            end
            OPC_LOAD: begin
                imm_type     = IMM_I;
                rd_sel       = 2'b11;
                reg_wr       = load_phase;
                mem_size     = func3[1:0];
                mem_unsigned = func3[2];
                mem_addr_sel = ~load_phase;
                pc_sel       = load_phase ? 2'b01 : 2'b10;
            end
            OPC_STORE: begin
                imm_type     = IMM_S;
                mem_wr       = 1'b1;
                mem_size     = func3[1:0];
                mem_unsigned = func3[2];
                mem_addr_sel = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed bench for ctrl_unit: decode vectors plus LOAD phase sequencing.
module tb_ctrl_unit;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    logic       clk;
    logic       rst;
    logic [4:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       b;
    logic [2:0] imm_type;
    logic       alu1_sel;
    logic       alu2_sel;
    logic [3:0] alu_op;
    logic [1:0] rd_sel;
    logic       reg_wr;
    logic       mem_wr;
    logic [1:0] mem_size;
    logic       mem_unsigned;
    logic       mem_addr_sel;
    logic [1:0] pc_sel;
    logic       load_phase;

    int n_checks = 0;
    int n_fail   = 0;

    ctrl_unit dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .func3        (func3),
        .func7        (func7),
        .b            (b),
        .imm_type     (imm_type),
        .alu1_sel     (alu1_sel),
        .alu2_sel     (alu2_sel),
        .alu_op       (alu_op),
        .rd_sel       (rd_sel),
        .reg_wr       (reg_wr),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .mem_addr_sel (mem_addr_sel),
        .pc_sel       (pc_sel),
        .load_phase   (load_phase)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic bb);
        opcode = op;
        func3  = f3;
        func7  = f7;
        b      = bb;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        drive(OPC_LOAD, 3'b010, 7'b0, 1'b0);
        check("rst_load_phase", load_phase, 1'b0);
        check("rst_load_pc_sel", pc_sel, 2'b10);

        // decode vectors, reset held so load_phase stays 0
        drive(OPC_LUI, 3'b000, 7'b0, 1'b0);
        check("imm_lui", imm_type, 3'b001);
        check("rd_lui", rd_sel, 2'b00);
        drive(OPC_OP_IMM, 3'b000, 7'b0100000, 1'b0);
        check("imm_opimm", imm_type, 3'b100);
        check("alu_addi_no_sub", alu_op, 4'b0000);
        drive(OPC_STORE, 3'b001, 7'b0, 1'b0);
        check("imm_store", imm_type, 3'b011);
        check("st_reg_wr", reg_wr, 1'b0);
        check("st_mem_wr", mem_wr, 1'b1);
        check("st_addr_sel", mem_addr_sel, 1'b1);
        check("st_mem_size", mem_size, 2'b01);
        drive(OPC_JAL, 3'b000, 7'b0, 1'b0);
        check("imm_jal", imm_type, 3'b010);
        check("jal_alu1", alu1_sel, 1'b1);
        check("jal_rd_sel", rd_sel, 2'b01);
        check("jal_pc_sel", pc_sel, 2'b00);
        check("jal_reg_wr", reg_wr, 1'b1);
        drive(OPC_BRANCH, 3'b000, 7'b0, 1'b0);
        check("imm_branch", imm_type, 3'b101);
        check("br_nt_pc_sel", pc_sel, 2'b01);
        drive(OPC_BRANCH, 3'b000, 7'b0, 1'b1);
        check("br_t_pc_sel", pc_sel, 2'b00);
        check("br_t_reg_wr", reg_wr, 1'b0);
        drive(OPC_JALR, 3'b000, 7'b0, 1'b0);
        check("jalr_pc_sel", pc_sel, 2'b00);
        drive(OPC_OP, 3'b000, 7'b0100000, 1'b0);
        check("op_alu2", alu2_sel, 1'b0);
        check("op_rd_sel", rd_sel, 2'b10);
        check("alu_sub", alu_op, 4'b1000);
        drive(OPC_OP, 3'b101, 7'b0100000, 1'b0);
        check("alu_sra", alu_op, 4'b1101);
        drive(OPC_OP, 3'b111, 7'b0100000, 1'b0);
        check("alu_and_f7_ignored", alu_op, 4'b0111);
        drive(OPC_OP_IMM, 3'b101, 7'b0100000, 1'b0);
        check("alu_srai", alu_op, 4'b1101);
        drive(OPC_OP_IMM, 3'b100, 7'b0, 1'b0);
        check("alu_xori", alu_op, 4'b0100);
        drive(5'b10101, 3'b000, 7'b0, 1'b0);
        check("unk_alu2", alu2_sel, 1'b1);
        check("unk_reg_wr", reg_wr, 1'b0);
        check("unk_imm", imm_type, 3'b000);
        drive(OPC_LOAD, 3'b101, 7'b0, 1'b0);
        check("ld_mem_size", mem_size, 2'b01);
        check("ld_unsigned", mem_unsigned, 1'b1);

        // LOAD sequencing
        @(negedge clk);
        drive(OPC_LOAD, 3'b010, 7'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("ld0_pc_sel", pc_sel, 2'b10);
        check("ld0_reg_wr", reg_wr, 1'b0);
        check("ld0_addr_sel", mem_addr_sel, 1'b1);
        @(posedge clk); #1;
        check("ld1_phase", load_phase, 1'b1);
        check("ld1_pc_sel", pc_sel, 2'b01);
        check("ld1_reg_wr", reg_wr, 1'b1);
        check("ld1_rd_sel", rd_sel, 2'b11);
        check("ld1_addr_sel", mem_addr_sel, 1'b0);
        @(posedge clk); #1;
        check("ld2_phase", load_phase, 1'b0);
        @(posedge clk); #1;
        check("ld3_phase", load_phase, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_phase", load_phase, 1'b0);
        check("async_rst_pc_sel", pc_sel, 2'b10);

        // non-LOAD arriving in phase 1
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("ld4_phase", load_phase, 1'b1);
        @(negedge clk);
        drive(OPC_OP, 3'b000, 7'b0, 1'b0);
        check("op_in_ph1_reg_wr", reg_wr, 1'b1);
        check("op_in_ph1_pc_sel", pc_sel, 2'b01);
        check("op_in_ph1_rd_sel", rd_sel, 2'b10);
        @(posedge clk); #1;
        check("op_clears_phase", load_phase, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
